vend_coin_ctrl: RTL
===================

Name: vend_coin_ctrl

Overview:
- Parametrised drink-vending controller: accepts 1/2/5-unit coins, accumulates credit and pours once credit reaches PRICE.
- Pays change, or a full refund on cancel, as a sequence of 2-unit and 1-unit coin-return pulses, one coin per cycle.
- Sits between the coin validator front end (one decoded coin per cycle) and the pour valve / coin-return solenoids.
- Successor to the fixed-price 5-unit controller: generalised price, serial multi-coin change, cancel/refund, busy/reject handshake.

Parameters:
- PRICE, 5, drink price in coin units; legal range 1 to 2^CREDIT_W-5.
- CREDIT_W, 4, width of the credit and remaining-change registers; must satisfy PRICE+4 < 2^CREDIT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- coin_valid  in  1  one coin presented this cycle.
- coin_sel  in  2  coin value code: 0=1 unit, 1=2 units, 2=5 units, 3=invalid.
- cancel  in  1  refund request, level sampled each cycle.
- busy  out  1  high when state is not IDLE.
- coin_reject  out  1  one-cycle pulse: the coin was not accepted and is physically returned.
- pour  out  1  one-cycle pour pulse.
- ret1  out  1  one-cycle pulse: return one 1-unit coin.
- ret2  out  1  one-cycle pulse: return one 2-unit coin.
- credit  out  CREDIT_W  current accumulated credit.
- sales_cnt  out  16  vend counter (optional feature only).

Behaviour:
- Reset (async, any state): state=IDLE, credit=0, remaining=0; pour, ret1, ret2, coin_reject and sales_cnt are 0.
- All outputs are registered.
- States:
  - IDLE: accepting coins.
  - VEND: pour=1 for exactly one cycle.
  - CHANGE: dispensing remaining.
- IDLE, coin_valid with a legal code and cancel=0:
  - credit_next = credit + value.
  - If credit_next >= PRICE: next state VEND, remaining = credit_next - PRICE, credit cleared to 0.
  - Otherwise: stay in IDLE, credit = credit_next.
  - Latency: a coin in cycle t gives pour in cycle t+1.
- IDLE, coin_sel=3: coin_reject pulses in cycle t+1; credit unchanged.
- IDLE, cancel=1:
  - Any coin in the same cycle is rejected (coin_reject at t+1).
  - If credit>0: remaining = credit, credit = 0, next state CHANGE, no pour.
  - If credit==0: no effect.
- VEND: next state CHANGE if remaining>0, else IDLE.
- CHANGE, one coin per cycle:
  - If remaining>=2: ret2=1, remaining -= 2.
  - Else: ret1=1, remaining -= 1.
  - Return to IDLE in the cycle after remaining reaches 0.
  - ret1 and ret2 are never high together.
- Busy states (VEND, CHANGE): every coin_valid produces coin_reject at t+1 and credit is unaffected; cancel is ignored.
- Back-to-back: IDLE accepts a new coin in the first IDLE cycle after dispensing ends.
- Arithmetic: credit+value is computed CREDIT_W+1 wide. Credit never exceeds PRICE+4, so no overflow within the legal parameter range.

Optional Feature:
- Macro: VEND_SALES_CNT_EN.
- Defined: sales_cnt increments by 1 on entry to VEND and saturates at 16'hFFFF; reset to 0 by rst only.
- Undefined: no counter logic; sales_cnt is tied to 0. The port list is identical in both builds.

Decomposition:
- Package vend_pkg:
  - State enum: IDLE, VEND, CHANGE.
  - Coin code localparams: COIN_1, COIN_2, COIN_5, COIN_BAD.
  - Function coin_value(code) returning the coin value in units.
- Sub-module vend_change_disp:
  - Loads remaining; emits ret2/ret1 each cycle; signals done.
  - Reused by the top-level FSM for both the VEND-change path and the cancel path.

Test Plan:
- PRICE=5; coins 2,2,2 on consecutive cycles → pour one cycle after the third coin, then ret1 for one cycle, then IDLE with credit=0.
- Coins 2,2 then 5 → credit 9 → pour, then ret2, ret2 on two consecutive cycles; no ret1.
- Coins 1,2 then cancel → no pour; ret2 then ret1; credit=0.
- Coin during VEND or CHANGE (e.g. 5 presented while ret2 is active) → coin_reject at t+1; dispense sequence and credit unaffected.
- coin_sel=3 in IDLE → coin_reject; credit unchanged. Cancel with credit=0 → no outputs.
- Reset asserted mid-CHANGE → all outputs 0 immediately, credit=0; with VEND_SALES_CNT_EN defined, sales_cnt=0 after reset and 3 after three full vends.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vending controller: FSM states, coin codes and coin values.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam logic [1:0] COIN_1   = 2'd0;
    localparam logic [1:0] COIN_2   = 2'd1;
    localparam logic [1:0] COIN_5   = 2'd2;
    localparam logic [1:0] COIN_BAD = 2'd3;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  coin_value = 3'd1;
            COIN_2:  coin_value = 3'd2;
            COIN_5:  coin_value = 3'd5;
            default: coin_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_coin_ctrl_if.sv
// Coin-validator / actuator bundle of the vending controller.
// master = front end + actuators (testbench or board glue), slave = the controller.
interface vend_coin_ctrl_if #(
    parameter int CREDIT_W = 4
);
    logic                coin_valid;
    logic [1:0]          coin_sel;
    logic                cancel;
    logic                busy;
    logic                coin_reject;
    logic                pour;
    logic                ret1;
    logic                ret2;
    logic [CREDIT_W-1:0] credit;
    logic [15:0]         sales_cnt;

    modport master (
        output coin_valid, coin_sel, cancel,
        input  busy, coin_reject, pour, ret1, ret2, credit, sales_cnt
    );

    modport slave (
        input  coin_valid, coin_sel, cancel,
        output busy, coin_reject, pour, ret1, ret2, credit, sales_cnt
    );
endinterface

// File: rtl/vend_change_disp.sv
// Change dispenser: holds the amount still owed and pays it out one coin per step,
// largest coin first. load_i with step_i pays the first coin of a freshly loaded amount.
module vend_change_disp #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] amt_i,
    output logic         ret1_o,
    output logic         ret2_o,
    output logic         done_o
);
    logic [W-1:0] rem_q, rem_d, src;
    logic         ret1_q, ret1_d;
    logic         ret2_q, ret2_d;

    always_comb begin
        src    = load_i ? amt_i : rem_q;
        rem_d  = src;
        ret1_d = 1'b0;
        ret2_d = 1'b0;
        if (step_i) begin
            if (src >= W'(2)) begin
                ret2_d = 1'b1;
                rem_d  = src - W'(2);
            end else if (src != '0) begin
                ret1_d = 1'b1;
                rem_d  = src - W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            ret1_q <= 1'b0;
            ret2_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            ret1_q <= ret1_d;
            ret2_q <= ret2_d;
        end
    end

    assign ret1_o = ret1_q;
    assign ret2_o = ret2_q;
    assign done_o = (rem_q == '0);
endmodule

// File: rtl/vend_coin_ctrl.sv
// Vending controller: accumulates coins, pours at PRICE, pays change/refunds serially.
// Optional vend counter on sales_cnt when VEND_SALES_CNT_EN is defined.
module vend_coin_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE    = 5,
    parameter int CREDIT_W = 4
) (
    input logic              clk,
    input logic              rst,
    vend_coin_ctrl_if.slave  bus
);
    localparam logic [CREDIT_W:0] PRICE_W = PRICE[CREDIT_W:0];

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W:0]   credit_next;
    logic                busy_q, pour_q, pour_d, reject_q, reject_d;
    logic                coin_ok;
    logic                disp_load, disp_step, disp_done;
    logic [CREDIT_W-1:0] disp_amt;
    logic                ret1, ret2;

    assign credit_next = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(bus.coin_sel));
    assign coin_ok     = bus.coin_valid && (bus.coin_sel != COIN_BAD) && !bus.cancel;

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        pour_d    = 1'b0;
        disp_load = 1'b0;
        disp_step = 1'b0;
        disp_amt  = '0;
        // Busy states, bad codes and coins racing a cancel are all handed back.
        reject_d  = bus.coin_valid &&
                    ((state_q != IDLE) || (bus.coin_sel == COIN_BAD) || bus.cancel);
        case (state_q)
            IDLE: begin
                if (bus.cancel) begin
                    if (credit_q != '0) begin
                        disp_amt  = credit_q;
                        disp_load = 1'b1;
                        disp_step = 1'b1;
                        credit_d  = '0;
                        state_d   = CHANGE;
                    end
                end else if (coin_ok) begin
                    if (credit_next >= PRICE_W) begin
                        disp_amt  = CREDIT_W'(credit_next - PRICE_W);
                        disp_load = 1'b1;
                        credit_d  = '0;
                        pour_d    = 1'b1;
                        state_d   = VEND;
                    end else begin
                        credit_d = CREDIT_W'(credit_next);
                    end
                end
            end
            VEND: begin
                if (!disp_done) begin
                    disp_step = 1'b1;
                    state_d   = CHANGE;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                if (!disp_done) begin
                    disp_step = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            busy_q   <= 1'b0;
            pour_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            busy_q   <= (state_d != IDLE);
            pour_q   <= pour_d;
            reject_q <= reject_d;
        end
    end

    vend_change_disp #(.W(CREDIT_W)) u_disp (
        .clk    (clk),
        .rst    (rst),
        .load_i (disp_load),
        .step_i (disp_step),
        .amt_i  (disp_amt),
        .ret1_o (ret1),
        .ret2_o (ret2),
        .done_o (disp_done)
    );

`ifdef VEND_SALES_CNT_EN
    logic [15:0] sales_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sales_q <= '0;
        end else if (pour_d && (sales_q != 16'hFFFF)) begin
            sales_q <= sales_q + 16'd1;
        end
    end

    assign bus.sales_cnt = sales_q;
`else
    assign bus.sales_cnt = '0;
`endif

    assign bus.busy        = busy_q;
    assign bus.pour        = pour_q;
    assign bus.coin_reject = reject_q;
    assign bus.ret1        = ret1;
    assign bus.ret2        = ret2;
    assign bus.credit      = credit_q;
endmodule
